// File: rtl/key_serializer.sv
`default_nettype none
// ============================================================================
// Module   : key_serializer
// Purpose  : Captures CHANNELS x WIDTH button levels and shifts them out
//            MSB-first on a single serial line. The rising edge of the load
//            strobe (hsync) captures the synchronised keys. The shift strobe
//            (pvalid) advances the shift register. FILL is shifted in behind
//            the data.
// Ports    : clk       - system clock
//            rstn      - asynchronous active-low reset
//            key       - raw button levels (asynchronous), channel
//                        CHANNELS-1 in the MSBs
//            load      - load strobe; only its rising edge loads
//            shift     - shift enable; ignored while load is high
//            skey      - serial key bit (MSB of the shift register)
//            busy      - unshifted data bits remain
//            bits_left - count of data bits not yet shifted out
//            overrun   - one-cycle pulse when a load edge arrives while busy
// Options  : KEY_DEBOUNCE_EN - when defined, each key bit is debounced over a
//            DEB_CYCLES stability window before it can be loaded.
// Revision : 1.0 - initial release
// ============================================================================
module key_serializer #(
  parameter int   WIDTH       = 8,
  parameter int   CHANNELS    = 1,
  parameter logic FILL        = 1'b0,
  parameter int   SYNC_STAGES = 2,
  parameter int   DEB_CYCLES  = 1024
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [CHANNELS*WIDTH-1:0]            key,
  input  logic                                 load,
  input  logic                                 shift,
  output logic                                 skey,
  output logic                                 busy,
  output logic [$clog2(CHANNELS*WIDTH+1)-1:0]  bits_left,
  output logic                                 overrun
);

  localparam int              N       = CHANNELS * WIDTH;
  localparam int              BL_W    = $clog2(N + 1);
  localparam logic [BL_W-1:0] BL_FULL = BL_W'(N);

  // Reject configurations the synchroniser and debouncer cannot support.
  if (SYNC_STAGES < 2 || DEB_CYCLES < 1) begin : g_param_check
    $error("key_serializer: SYNC_STAGES must be >= 2 and DEB_CYCLES >= 1");
  end

  // --------------------------------------------------------------------------
  // Key synchroniser: stage 0 samples the raw pins, stage SYNC_STAGES-1 is
  // the clean value.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [SYNC_STAGES-1:0][N-1:0] sync_d;
  logic [N-1:0]                  ksync;
  logic [N-1:0]                  kval;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], key};
  end

  assign ksync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

`ifdef KEY_DEBOUNCE_EN
  // --------------------------------------------------------------------------
  // Debouncer: a bit's counter runs while the synchronised level disagrees
  // with the accepted level. The accepted level flips on the DEB_CYCLES-th
  // consecutive disagreeing cycle; any agreement restarts the window.
  // --------------------------------------------------------------------------
  localparam int               CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [N-1:0]            deb_q;
  logic [N-1:0]            deb_d;
  logic [N-1:0][CNT_W-1:0] cnt_q;
  logic [N-1:0][CNT_W-1:0] cnt_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < N; i++) begin
      if (ksync[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = ~deb_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      deb_q <= '0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign kval = deb_q;
`else
  assign kval = ksync;
`endif

  // --------------------------------------------------------------------------
  // Load edge detection and shift register.
  // --------------------------------------------------------------------------
  logic            load_d_q;
  logic            load_edge;
  logic [N-1:0]    sr_q;
  logic [N-1:0]    sr_d;
  logic [BL_W-1:0] bits_left_q;
  logic [BL_W-1:0] bits_left_d;
  logic            overrun_q;
  logic            overrun_d;

  assign load_edge = load & ~load_d_q;

  always_comb begin
    sr_d        = sr_q;
    bits_left_d = bits_left_q;
    overrun_d   = 1'b0;
    if (load_edge) begin
      // The load wins over a simultaneous shift.
      sr_d        = kval;
      bits_left_d = BL_FULL;
      overrun_d   = (bits_left_q != '0);
    end else if (!load && shift) begin
      // Shifting continues once the data is gone; sr already holds FILL, and
      // the count saturates at zero.
      sr_d    = sr_q << 1;
      sr_d[0] = FILL;
      if (bits_left_q != '0) begin
        bits_left_d = bits_left_q - BL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      load_d_q    <= 1'b0;
      sr_q        <= {N{FILL}};
      bits_left_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      load_d_q    <= load;
      sr_q        <= sr_d;
      bits_left_q <= bits_left_d;
      overrun_q   <= overrun_d;
    end
  end

  assign skey      = sr_q[N-1];
  assign busy      = (bits_left_q != '0);
  assign bits_left = bits_left_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_key_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_serializer
// Purpose  : Self-checking bench for key_serializer (WIDTH=8, CHANNELS=2).
//            A word-level model (loaded word + remaining count) predicts the
//            outputs every cycle; directed sequences pin the model with
//            hand-computed values, then randomized traffic follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_serializer;

  localparam int   WIDTH       = 8;
  localparam int   CHANNELS    = 2;
  localparam int   SYNC_STAGES = 2;
  localparam int   DEB_CYCLES  = 16;
  localparam logic FILL        = 1'b0;
  localparam int   N           = WIDTH * CHANNELS;
  localparam int   BL_W        = $clog2(N + 1);
`ifdef KEY_DEBOUNCE_EN
  localparam int   HOLD        = SYNC_STAGES + DEB_CYCLES + 4;
  localparam int   KEY_CHG     = 40;
`else
  localparam int   HOLD        = SYNC_STAGES + 2;
  localparam int   KEY_CHG     = 6;
`endif

  logic            clk  = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    key  = '0;
  logic            load = 1'b0;
  logic            shift = 1'b0;
  logic            skey;
  logic            busy;
  logic            overrun;
  logic [BL_W-1:0] bits_left;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_serializer #(
    .WIDTH      (WIDTH),
    .CHANNELS   (CHANNELS),
    .FILL       (FILL),
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .key      (key),
    .load     (load),
    .shift    (shift),
    .skey     (skey),
    .busy     (busy),
    .bits_left(bits_left),
    .overrun  (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: the last loaded word and how many of its bits are still
  // to be shifted. skey is word[count-1] while count>0, FILL afterwards.
  // The key value visible to a load is the key as it stood SYNC_STAGES
  // clock edges earlier (zero before enough history exists after reset).
  // --------------------------------------------------------------------------
  logic [N-1:0] m_word      = '0;
  int           m_count     = 0;
  logic         m_overrun   = 1'b0;
  logic         m_load_prev = 1'b0;
  logic [N-1:0] m_key_hist[$];
`ifdef KEY_DEBOUNCE_EN
  logic [N-1:0] m_deb = '0;
  logic [N-1:0] m_ks_hist[$];
`endif

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_word      = '0;
      m_count     = 0;
      m_overrun   = 1'b0;
      m_load_prev = 1'b0;
      m_key_hist.delete();
`ifdef KEY_DEBOUNCE_EN
      m_deb = '0;
      m_ks_hist.delete();
`endif
    end else begin
      logic [N-1:0] ks;
      logic [N-1:0] kv;
      bit           edge_now;
      ks = (m_key_hist.size() >= SYNC_STAGES) ? m_key_hist[SYNC_STAGES-1] : '0;
      m_key_hist.push_front(key);
      if (m_key_hist.size() > SYNC_STAGES) void'(m_key_hist.pop_back());
`ifdef KEY_DEBOUNCE_EN
      // Accepted level flips once the last DEB_CYCLES synchronised samples
      // all disagree with it.
      kv = m_deb;
      m_ks_hist.push_front(ks);
      if (m_ks_hist.size() > DEB_CYCLES) void'(m_ks_hist.pop_back());
      if (m_ks_hist.size() == DEB_CYCLES) begin
        for (int b = 0; b < N; b++) begin
          bit all_diff;
          all_diff = 1'b1;
          foreach (m_ks_hist[j]) if (m_ks_hist[j][b] == m_deb[b]) all_diff = 1'b0;
          if (all_diff) m_deb[b] = ~m_deb[b];
        end
      end
`else
      kv = ks;
`endif
      edge_now    = load && !m_load_prev;
      m_load_prev = load;
      m_overrun   = edge_now && (m_count > 0);
      if (edge_now) begin
        m_word  = kv;
        m_count = N;
      end else if (!load && shift && m_count > 0) begin
        m_count = m_count - 1;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic exp_skey;
    exp_skey = (m_count > 0) ? m_word[m_count-1] : FILL;
    check("model_skey", 32'(skey), 32'(exp_skey));
    check("model_busy", 32'(busy), 32'(m_count > 0));
    check("model_bits_left", 32'(bits_left), 32'(m_count));
    check("model_overrun", 32'(overrun), 32'(m_overrun));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] pat;

    // Reset state
    rstn = 1'b0;
    repeat (3) tick();
    check("reset_skey", 32'(skey), 32'(FILL));
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_bits_left", 32'(bits_left), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    rstn = 1'b1;

    // Load A55A and shift out MSB first
    pat = 16'hA55A;
    key = pat;
    repeat (HOLD) tick();
    load = 1'b1;
    tick();
    check("a55a_first_bit", 32'(skey), 32'(pat[15]));
    check("a55a_bits_left_full", 32'(bits_left), 32'd16);
    check("a55a_busy", 32'(busy), 32'd1);
    load  = 1'b0;
    shift = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("a55a_bits_left", 32'(bits_left), 32'(16 - i));
      if (i < 16) check("a55a_skey", 32'(skey), 32'(pat[15-i]));
    end
    check("a55a_done_skey", 32'(skey), 32'(FILL));
    check("a55a_done_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    check("a55a_fill_skey", 32'(skey), 32'(FILL));
    check("a55a_no_underflow", 32'(bits_left), 32'd0);

    // Load held high with shift active: one load, no shifting while high
    key = 16'hFFFF;
    repeat (HOLD) tick();
    load = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_bits_left", 32'(bits_left), 32'd16);
      check("hold_skey", 32'(skey), 32'd1);
    end
    load = 1'b0;
    tick();
    check("hold_fall_bits_left", 32'(bits_left), 32'd15);

    // Overrun: reload after 9 shifts
    shift = 1'b0;
    key   = 16'hA55A;
    repeat (HOLD) tick();
    load = 1'b1;
    tick();
    load  = 1'b0;
    shift = 1'b1;
    repeat (5) tick();
    key = 16'h0001;
    repeat (4) tick();
    check("ovr_bits_left_before", 32'(bits_left), 32'd7);
    load = 1'b1;
    tick();
    check("ovr_pulse", 32'(overrun), 32'd1);
    check("ovr_bits_left_restart", 32'(bits_left), 32'd16);
`ifndef KEY_DEBOUNCE_EN
    check("ovr_new_msb", 32'(skey), 32'd0);
`endif
    load = 1'b0;
    tick();
    check("ovr_cleared", 32'(overrun), 32'd0);
    check("ovr_bits_left_15", 32'(bits_left), 32'd15);
    repeat (14) tick();
    check("ovr_bits_left_1", 32'(bits_left), 32'd1);
`ifndef KEY_DEBOUNCE_EN
    check("ovr_new_lsb", 32'(skey), 32'd1);
`endif

    // Key change one cycle before the load edge is not yet visible
    shift = 1'b0;
    key   = 16'h0000;
    repeat (HOLD) tick();
    key = 16'hFFFF;
    tick();
    load = 1'b1;
    tick();
    check("sync_latency_skey", 32'(skey), 32'd0);
    load  = 1'b0;
    shift = 1'b1;
    tick();
    check("sync_latency_skey2", 32'(skey), 32'd0);

    // Reset mid-shift with bits_left = 5
    shift = 1'b0;
    key   = 16'hA55A;
    repeat (HOLD) tick();
    load = 1'b1;
    tick();
    load  = 1'b0;
    shift = 1'b1;
    repeat (11) tick();
    check("rst_mid_bits_left", 32'(bits_left), 32'd5);
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_skey", 32'(skey), 32'(FILL));
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_bits_left0", 32'(bits_left), 32'd0);
    check("rst_mid_overrun", 32'(overrun), 32'd0);
    tick();
    rstn = 1'b1;
    repeat (HOLD) tick();
    check("rst_after_idle", 32'(bits_left), 32'd0);
    load = 1'b1;
    tick();
    check("rst_reload_bits_left", 32'(bits_left), 32'd16);
    check("rst_reload_skey", 32'(skey), 32'd1);
    load = 1'b0;

`ifdef KEY_DEBOUNCE_EN
    // Short glitch rejected, long change accepted (bit 3 reaches skey
    // after 12 shifts)
    shift = 1'b0;
    key   = '0;
    repeat (HOLD) tick();
    key[3] = 1'b1;
    repeat (10) tick();
    key[3] = 1'b0;
    repeat (HOLD) tick();
    load = 1'b1;
    tick();
    load  = 1'b0;
    shift = 1'b1;
    repeat (12) tick();
    check("deb_glitch_bit3", 32'(skey), 32'd0);
    shift  = 1'b0;
    key[3] = 1'b1;
    repeat (20) tick();
    load = 1'b1;
    tick();
    load  = 1'b0;
    shift = 1'b1;
    repeat (12) tick();
    check("deb_accept_bit3", 32'(skey), 32'd1);
`endif

    // Randomized traffic checked by the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, KEY_CHG - 1) == 0) key = N'($urandom);
      load  = ($urandom_range(0, 9) == 0) ? ~load : load;
      if (load && $urandom_range(0, 3) == 0) load = 1'b0;
      shift = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 699) == 0) begin
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
      end
      tick();
    end

    load  = 1'b0;
    shift = 1'b0;
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
